// File: rtl/matmul_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl_if
//   Bundles every non-clock/reset signal of the matmul host sequencer:
//   the job start strobe, the A/B row input stream, the C row output stream,
//   status flags, and the full control/data pin set of the systolic matmul
//   wrapper.
//
//   modport master : the sequencer side (drives wrapper pins, in_ready,
//                    out_valid/out_data, busy, job_done).
//   modport slave  : the environment side (host stream source/sink and the
//                    wrapper itself).
//
//   Signals:
//     go                      job start strobe (sampled only when idle)
//     in_valid/in_ready/in_data    A rows then B rows
//     out_valid/out_ready/out_data C rows in ascending address order
//     busy, job_done          status
//     enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
//     we_a, we_b, we_c, start_mat_mul      to wrapper
//     done_mat_mul, data_from_out_mat       from wrapper
//     err                     compute watchdog flag, present only when
//                             MATMUL_SEQ_TIMEOUT_EN is defined
// ---------------------------------------------------------------------------
interface matmul_seq_ctrl_if #(
    parameter int BUS_W  = 256,
    parameter int AWIDTH = 7
);
    logic              go;
    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BUS_W-1:0]  out_data;
    logic              busy;
    logic              job_done;
    logic              enable_writing_to_mem;
    logic              enable_reading_from_mem;
    logic [AWIDTH-1:0] addr_pi;
    logic [BUS_W-1:0]  data_pi;
    logic              we_a;
    logic              we_b;
    logic              we_c;
    logic              start_mat_mul;
    logic              done_mat_mul;
    logic [BUS_W-1:0]  data_from_out_mat;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic              err;
`endif

    modport master (
        input  go, in_valid, in_data, out_ready, done_mat_mul, data_from_out_mat,
        output in_ready, out_valid, out_data, busy, job_done,
               enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
               we_a, we_b, we_c, start_mat_mul
`ifdef MATMUL_SEQ_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output go, in_valid, in_data, out_ready, done_mat_mul, data_from_out_mat,
        input  in_ready, out_valid, out_data, busy, job_done,
               enable_writing_to_mem, enable_reading_from_mem, addr_pi, data_pi,
               we_a, we_b, we_c, start_mat_mul
`ifdef MATMUL_SEQ_TIMEOUT_EN
        , input err
`endif
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
//   Host-side sequencer for the 32x32 fp16 systolic matmul wrapper. One job:
//   load A_WORDS rows into the A banks and B_WORDS rows into the B banks from
//   a valid/ready stream, flush the delayed write pipe, run the compute with
//   C capture enabled until the wrapper reports done, then read C_WORDS rows
//   back through a credit-limited output FIFO.
//
//   Ports:
//     clk      controller clock; the wrapper compute and memory clocks are
//              tied to the same net
//     reset_n  asynchronous active-low reset; aborts any job silently
//     bus      matmul_seq_ctrl_if.master (stream, status and wrapper pins)
//
//   Optional build macro MATMUL_SEQ_TIMEOUT_EN adds a compute watchdog
//   (parameter TIMEOUT_CYCLES, output bus.err). Without it COMPUTE waits for
//   done_mat_mul indefinitely.
// ---------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int BUS_W          = 256,
    parameter int AWIDTH         = 7,
    parameter int A_WORDS        = 32,
    parameter int B_WORDS        = 32,
    parameter int C_WORDS        = 16,
    parameter int WE_DLY         = 2,
    parameter int READ_LAT       = 4,
    parameter int OUT_FIFO_DEPTH = 8
`ifdef MATMUL_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    matmul_seq_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int FL_W  = $clog2(WE_DLY + 2);

    localparam logic [AWIDTH-1:0] A_LAST   = AWIDTH'(A_WORDS - 1);
    localparam logic [AWIDTH-1:0] B_LAST   = AWIDTH'(B_WORDS - 1);
    localparam logic [AWIDTH-1:0] C_LAST   = AWIDTH'(C_WORDS - 1);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(WE_DLY);
    localparam logic [SUM_W-1:0]  DEPTH_S  = SUM_W'(OUT_FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(OUT_FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FLUSH,
        S_COMPUTE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t            state, state_d;
    logic [AWIDTH-1:0] cnt, cnt_d;
    logic [FL_W-1:0]   flush_cnt, flush_d;
    logic              comp_first, comp_first_d;

    logic accept;
    logic issue;
    logic push;
    logic pop;
    logic room;
    logic fifo_nempty;
    logic done_seen;

    // write delay line: index = stage, last stage lines up with the wrapper
    // address pipeline
    logic [BUS_W-1:0]  wr_data_p [WE_DLY];
    logic [WE_DLY-1:0] wr_a_p;
    logic [WE_DLY-1:0] wr_b_p;

    // read return tracking: vld_p[i] is a read issued i+1 cycles ago
    logic [READ_LAT-1:0] rd_vld_p;
    logic [CNT_W-1:0]    inflight;

    logic [BUS_W-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    assign accept      = bus.in_valid && ((state == S_LOAD_A) || (state == S_LOAD_B));
    // credit check covers both stored rows and rows still in the read
    // pipeline, so every issued read has a guaranteed FIFO slot
    assign room        = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_S;
    assign issue       = (state == S_READ) && room;
    assign push        = rd_vld_p[READ_LAT-1];
    assign fifo_nempty = (fifo_count != '0);
    assign pop         = fifo_nempty && bus.out_ready;
    // the wrapper may still show done from a previous run on entry
    assign done_seen   = bus.done_mat_mul && !comp_first;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            timeout;

    assign timeout = (state == S_COMPUTE) && !done_seen && (wd_cnt == WD_LAST);
    assign bus.err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_COMPUTE) ? wd_cnt + 1'b1 : '0;
            if ((state == S_IDLE) && bus.go) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

    // ---- control state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            flush_cnt  <= '0;
            comp_first <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            flush_cnt  <= flush_d;
            comp_first <= comp_first_d;
        end
    end

    // ---- next state and control outputs ----
    always_comb begin
        state_d                     = state;
        cnt_d                       = cnt;
        flush_d                     = flush_cnt;
        comp_first_d                = 1'b0;
        bus.in_ready                = 1'b0;
        bus.enable_writing_to_mem   = 1'b0;
        bus.enable_reading_from_mem = 1'b0;
        bus.addr_pi                 = '0;
        bus.start_mat_mul           = 1'b0;
        bus.we_c                    = 1'b0;
        bus.job_done                = 1'b0;
        bus.busy                    = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                end
            end
            S_LOAD_A: begin
                bus.in_ready              = 1'b1;
                bus.enable_writing_to_mem = 1'b1;
                bus.addr_pi               = cnt;
                if (bus.in_valid) begin
                    if (cnt == A_LAST) begin
                        state_d = S_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                bus.in_ready              = 1'b1;
                bus.enable_writing_to_mem = 1'b1;
                bus.addr_pi               = cnt;
                if (bus.in_valid) begin
                    if (cnt == B_LAST) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                        flush_d = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                // keep write enable up until the last delayed write lands
                bus.enable_writing_to_mem = 1'b1;
                if (flush_cnt == FL_LAST) begin
                    state_d      = S_COMPUTE;
                    comp_first_d = 1'b1;
                end else begin
                    flush_d = flush_cnt + 1'b1;
                end
            end
            S_COMPUTE: begin
                bus.start_mat_mul = 1'b1;
                bus.we_c          = 1'b1;
                if (done_seen) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (timeout) begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_READ: begin
                bus.enable_reading_from_mem = 1'b1;
                bus.addr_pi                 = cnt;
                if (issue) begin
                    if (cnt == C_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                bus.enable_reading_from_mem = 1'b1;
                // all reads issued: the last row is the only one left when
                // nothing is in flight and exactly one entry is stored
                if (pop && (inflight == '0) && (fifo_count == CNT_W'(1))) begin
                    bus.job_done = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---- write stage p0 .. p(WE_DLY-1) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WE_DLY; i++) begin
                wr_data_p[i] <= '0;
            end
            wr_a_p <= '0;
            wr_b_p <= '0;
        end else begin
            wr_data_p[0] <= accept ? bus.in_data : '0;
            wr_a_p[0]    <= accept && (state == S_LOAD_A);
            wr_b_p[0]    <= accept && (state == S_LOAD_B);
            for (int i = 1; i < WE_DLY; i++) begin
                wr_data_p[i] <= wr_data_p[i-1];
                wr_a_p[i]    <= wr_a_p[i-1];
                wr_b_p[i]    <= wr_b_p[i-1];
            end
        end
    end

    assign bus.data_pi = wr_data_p[WE_DLY-1];
    assign bus.we_a    = wr_a_p[WE_DLY-1];
    assign bus.we_b    = wr_b_p[WE_DLY-1];

    // ---- read return stage p0 .. p(READ_LAT-1) and credit count ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p <= '0;
            inflight <= '0;
        end else begin
            rd_vld_p[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
            unique case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // ---- output FIFO (first-word-fall-through from the head entry) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_from_out_mat;
        end
    end

    assign bus.out_valid = fifo_nempty;
    assign bus.out_data  = fifo_nempty ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//   Scoreboard bench for matmul_seq_ctrl. Stimulus pushes expected BRAM
//   writes, compute lengths and C rows into queues; independent monitors pop
//   and compare whenever the DUT shows a write, ends a compute run or hands
//   over a C row. A small wrapper model answers done_mat_mul and returns
//   addr+0x1000 READ_LAT cycles after each address.
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int BUS_W    = 256;
    localparam int AWIDTH   = 7;
    localparam int READ_LAT = 4;
    localparam int C_WORDS  = 16;

    typedef struct {
        logic              b;
        logic [AWIDTH-1:0] addr;
        logic [BUS_W-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.BUS_W(BUS_W), .AWIDTH(AWIDTH)) bus ();

    matmul_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    wr_t              exp_wr[$];
    logic [BUS_W-1:0] exp_rd[$];
    int               exp_cmp[$];

    int jobs_done = 0;
    int rd_seen   = 0;
    int cmp_lat   = 50;
    int rdy_mode  = 0;
    int fifo_max  = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] rowval(input int v);
        logic [15:0] h;
        h = 16'(v);
        return {16{h}};
    endfunction

    // ---- out_ready driver ----
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 9) < 3);
            else               bus.out_ready = 1'b1;
        end
    end

    // ---- wrapper model: compute done ----
    initial begin
        int n;
        n = 0;
        bus.done_mat_mul = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || !bus.start_mat_mul) begin
                n = 0;
                bus.done_mat_mul = 1'b0;
            end else begin
                n++;
                if (n == cmp_lat) bus.done_mat_mul = 1'b1;
            end
        end
    end

    // ---- wrapper model: read data returns addr+0x1000 after READ_LAT ----
    initial begin
        logic [AWIDTH-1:0] rd_hist[$];
        bus.data_from_out_mat = '0;
        forever begin
            @(negedge clk);
            rd_hist.push_back(bus.addr_pi);
            if (rd_hist.size() > READ_LAT)
                bus.data_from_out_mat = 256'(rd_hist.pop_front()) + 256'(32'h1000);
        end
    end

    // ---- write monitor ----
    initial begin
        logic              acc_h1, acc_h2;
        logic [AWIDTH-1:0] a_h1, a_h2;
        wr_t               e;
        acc_h1 = 1'b0; acc_h2 = 1'b0; a_h1 = '0; a_h2 = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc_h1 = 1'b0; acc_h2 = 1'b0; a_h1 = '0; a_h2 = '0;
            end else begin
                if (bus.we_a || bus.we_b) begin
                    chk("wr_expected", 256'(exp_wr.size() != 0), 256'(1'b1));
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        chk("wr_we_b", 256'(bus.we_b), 256'(e.b));
                        chk("wr_we_a", 256'(bus.we_a), 256'(!e.b));
                        chk("wr_accept_2_before", 256'(acc_h2), 256'(1'b1));
                        chk("wr_addr_2_before", 256'(a_h2), 256'(e.addr));
                        chk("wr_data", bus.data_pi, e.data);
                    end
                end
                acc_h2 = acc_h1;
                a_h2   = a_h1;
                acc_h1 = bus.in_valid && bus.in_ready;
                a_h1   = bus.addr_pi;
            end
        end
    end

    // ---- compute monitor ----
    initial begin
        int st_run, wc_run, lat;
        st_run = 0; wc_run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                st_run = 0; wc_run = 0;
            end else if (bus.start_mat_mul || bus.we_c) begin
                if (bus.start_mat_mul) st_run++;
                if (bus.we_c) wc_run++;
            end else if (st_run > 0 || wc_run > 0) begin
                chk("cmp_expected", 256'(exp_cmp.size() != 0), 256'(1'b1));
                lat = (exp_cmp.size() != 0) ? exp_cmp.pop_front() : 0;
                chk("start_cycles", 256'(st_run), 256'(lat));
                chk("we_c_cycles", 256'(wc_run), 256'(lat));
                chk("rd_en_after_compute", 256'(bus.enable_reading_from_mem), 256'(1'b1));
                st_run = 0; wc_run = 0;
            end
        end
    end

    // ---- readback monitor ----
    initial begin
        logic [BUS_W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
                if (bus.job_done) jobs_done++;
                if (bus.out_valid && bus.out_ready) begin
                    rd_seen++;
                    chk("rd_expected", 256'(exp_rd.size() != 0), 256'(1'b1));
                    if (exp_rd.size() != 0) begin
                        e = exp_rd.pop_front();
                        chk("rd_data", bus.out_data, e);
                        chk("job_done_on_last", 256'(bus.job_done), 256'(exp_rd.size() == 0));
                    end
                end else if (bus.job_done) begin
                    chk("job_done_without_handshake", 256'(bus.job_done), 256'(1'b0));
                end
            end
        end
    end

    task automatic send_row(input logic b, input int idx, input logic [BUS_W-1:0] d, input int gap);
        wr_t e;
        int  g;
        e.b = b; e.addr = AWIDTH'(idx); e.data = d;
        exp_wr.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        chk("in_ready_load", 256'(bus.in_ready), 256'(1'b1));
        chk("busy_load", 256'(bus.busy), 256'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_job(input bit bubbles, input int lat, input int mode, input int abort_row);
        int done0, seen0, g;
        cmp_lat  = lat;
        rdy_mode = mode;
        exp_cmp.push_back(lat);
        for (int i = 0; i < C_WORDS; i++) exp_rd.push_back(256'(32'h1000 + i));
        done0 = jobs_done;
        seen0 = rd_seen;
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        for (int i = 0; i < 32; i++) send_row(1'b0, i, rowval(i), (bubbles && (i % 2 == 0)) ? 2 : 0);
        for (int i = 0; i < 32; i++) send_row(1'b1, i, rowval(100 + i), 0);
        g = 0;
        if (abort_row > 0) begin
            while (rd_seen < seen0 + abort_row && g < 3000) begin
                @(negedge clk);
                g++;
            end
            chk("abort_row_reached", 256'(rd_seen >= seen0 + abort_row), 256'(1'b1));
            #1;
            reset_n = 1'b0;
            #1;
            chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
            chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
            chk("rst_out_data", bus.out_data, 256'(0));
            chk("rst_busy", 256'(bus.busy), 256'(0));
            chk("rst_job_done", 256'(bus.job_done), 256'(0));
            chk("rst_en_wr", 256'(bus.enable_writing_to_mem), 256'(0));
            chk("rst_en_rd", 256'(bus.enable_reading_from_mem), 256'(0));
            chk("rst_addr_pi", 256'(bus.addr_pi), 256'(0));
            chk("rst_data_pi", bus.data_pi, 256'(0));
            chk("rst_we", 256'({bus.we_a, bus.we_b, bus.we_c}), 256'(0));
            chk("rst_start", 256'(bus.start_mat_mul), 256'(0));
            exp_rd.delete();
            repeat (3) @(posedge clk);
            #1;
            reset_n = 1'b1;
            @(posedge clk);
            #1;
            chk("no_job_done_after_abort", 256'(jobs_done), 256'(done0));
            chk("idle_after_abort", 256'(bus.busy), 256'(0));
        end else begin
            while (jobs_done == done0 && g < 3000) begin
                @(negedge clk);
                g++;
            end
            chk("job_completed", 256'(jobs_done - done0), 256'(1));
            @(negedge clk);
            chk("idle_after_job", 256'(bus.busy), 256'(0));
            chk("rows_delivered", 256'(rd_seen - seen0), 256'(C_WORDS));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.go       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset_n      = 1'b1;
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 256'(bus.busy), 256'(0));
        chk("reset_in_ready", 256'(bus.in_ready), 256'(0));
        chk("reset_out_valid", 256'(bus.out_valid), 256'(0));
        chk("reset_job_done", 256'(bus.job_done), 256'(0));
        chk("reset_addr_pi", 256'(bus.addr_pi), 256'(0));
        chk("reset_we", 256'({bus.we_a, bus.we_b, bus.we_c}), 256'(0));
        chk("reset_start", 256'(bus.start_mat_mul), 256'(0));
        chk("reset_en", 256'({bus.enable_writing_to_mem, bus.enable_reading_from_mem}), 256'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // in_valid while idle must not be accepted
        bus.in_valid = 1'b1;
        bus.in_data  = rowval(7);
        @(negedge clk);
        chk("in_ready_idle", 256'(bus.in_ready), 256'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        run_job(1'b0, 50, 0, 0);   // ramp load, no back-pressure
        run_job(1'b1, 20, 1, 0);   // input bubbles, random out_ready
        run_job(1'b0, 30, 1, 5);   // reset in the middle of readback
        run_job(1'b0, 50, 0, 0);   // clean restart after abort

        chk("total_jobs_done", 256'(jobs_done), 256'(3));
        chk("fifo_max_le_depth", 256'(fifo_max <= 8), 256'(1'b1));
        chk("wr_queue_empty", 256'(exp_wr.size()), 256'(0));
        chk("rd_queue_empty", 256'(exp_rd.size()), 256'(0));
        chk("cmp_queue_empty", 256'(exp_cmp.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
